// File: rtl/dmem_port_slice.sv
// dmem_port_slice: buffered dmem port with byte strobes, outstanding limit and pipelined responses
module dmem_port_slice #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RESP_STAGES = 1
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     cpu_req_valid,
  output logic                                     cpu_req_ready,
  input  logic                                     cpu_req_we,
  input  logic [ADDR_W-1:0]                        cpu_req_addr,
  input  logic [DATA_W-1:0]                        cpu_req_data,
  input  logic [1:0]                               cpu_req_size,
  output logic                                     mem_req_valid,
  input  logic                                     mem_req_ready,
  output logic                                     mem_req_we,
  output logic [ADDR_W-1:0]                        mem_req_addr,
  output logic [DATA_W-1:0]                        mem_req_data,
  output logic [DATA_W/8-1:0]                      mem_req_strb,
  input  logic                                     mem_resp_valid,
  input  logic [DATA_W-1:0]                        mem_resp_data,
  output logic                                     cpu_resp_valid,
  output logic [DATA_W-1:0]                        cpu_resp_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
  output logic                                     err_misaligned,
  output logic                                     err_spurious
);
  localparam int NB = DATA_W / 8;
  localparam int OFS = $clog2(NB);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int EW = 1 + ADDR_W + DATA_W + NB;
  logic [PW:0] wr_ptr, rd_ptr;
  logic [EW-1:0] fifo [FIFO_DEPTH];
  logic full, empty, accept, legal, push, issue, resp_ok;
  logic [7:0] base;
  logic [NB-1:0] strb;
  logic [DATA_W-1:0] wdata;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign cpu_req_ready = !full;
  assign accept = cpu_req_valid && cpu_req_ready;
  assign legal = cpu_req_size == 2'd0 ||
                 (cpu_req_size == 2'd1 && !cpu_req_addr[0]) ||
                 (cpu_req_size == 2'd2 && cpu_req_addr[1:0] == 2'b00) ||
                 (cpu_req_size == 2'd3 && DATA_W == 64 && cpu_req_addr[2:0] == 3'b000);
  assign push = accept && legal;
  assign base = cpu_req_size == 2'd0 ? 8'h01 : cpu_req_size == 2'd1 ? 8'h03 :
                cpu_req_size == 2'd2 ? 8'h0f : 8'hff;
  assign strb = NB'(base) << cpu_req_addr[OFS-1:0];
  for (genvar g = 0; g < NB; g++) begin : g_lane
    assign wdata[8*g +: 8] = cpu_req_size == 2'd0 ? cpu_req_data[7:0] :
                             cpu_req_size == 2'd1 ? cpu_req_data[8*(g%2) +: 8] :
                             cpu_req_size == 2'd2 ? cpu_req_data[8*(g%4) +: 8] :
                                                    cpu_req_data[8*(g%8) +: 8];
  end
  assign mem_req_valid = !empty && (outstanding < CW'(MAX_OUTSTANDING));
  assign {mem_req_we, mem_req_addr, mem_req_data, mem_req_strb} = fifo[rd_ptr[PW-1:0]];
  assign issue = mem_req_valid && mem_req_ready;
  // a response in the same cycle as the first issue is legitimate, not spurious
  assign resp_ok = mem_resp_valid && (outstanding != '0 || issue);
  always_ff @(posedge clock)
    if (push) fifo[wr_ptr[PW-1:0]] <= {cpu_req_we, cpu_req_addr, wdata, strb};
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      outstanding <= '0;
      err_misaligned <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      outstanding <= outstanding + CW'(issue) - CW'(resp_ok);
      err_misaligned <= accept && !legal;
      if (mem_resp_valid && !resp_ok) err_spurious <= 1'b1;
    end
  end
  if (RESP_STAGES == 0) begin : g_comb
    assign cpu_resp_valid = resp_ok;
    assign cpu_resp_data = mem_resp_data;
  end else begin : g_pipe
    logic [RESP_STAGES-1:0] pv;
    logic [DATA_W-1:0] pd [RESP_STAGES];
    always_ff @(posedge clock) begin
      if (reset) pv <= '0;
      else begin
        pv[0] <= resp_ok;
        for (int i = 1; i < RESP_STAGES; i++) pv[i] <= pv[i-1];
      end
      pd[0] <= mem_resp_data;
      for (int i = 1; i < RESP_STAGES; i++) pd[i] <= pd[i-1];
    end
    assign cpu_resp_valid = pv[RESP_STAGES-1];
    assign cpu_resp_data = pd[RESP_STAGES-1];
  end
endmodule
